// File: rtl/quad_pkg.sv
// Shared types and the Gray-code step decoder for the quadrature input filter.
package quad_pkg;

    typedef enum logic {INIT, TRACK} quad_state_t;

    typedef logic [1:0] quad_ab_t;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    // Position of {a,b} along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] quad_pos(input quad_ab_t ab);
        case (ab)
            2'b00:   quad_pos = 2'd0;
            2'b10:   quad_pos = 2'd1;
            2'b11:   quad_pos = 2'd2;
            default: quad_pos = 2'd3;
        endcase
    endfunction

    // Returns {valid, dir, err}; equal states yield all zeros.
    function automatic logic [2:0] quad_decode(input quad_ab_t prev, input quad_ab_t next);
        logic [1:0] delta;
        delta = quad_pos(next) - quad_pos(prev);
        case (delta)
            2'd1:    quad_decode = 3'b110;
            2'd3:    quad_decode = 3'b100;
            2'd2:    quad_decode = 3'b001;
            default: quad_decode = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Two-flop synchronizer plus stability counter for one encoder channel.
module quad_glitch_filter #(
    parameter int unsigned FILTER_CYCLES = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic commit,
    output logic sync
);

    logic        sync1_q, sync2_q;
    logic        dout_q, dout_d;
    logic        commit_q, commit_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        dout_d   = dout_q;
        commit_d = 1'b0;
        if (sync2_q != dout_q) begin
            if (({1'b0, cnt_q} + 17'd1) == 17'(FILTER_CYCLES)) begin
                dout_d   = sync2_q;
                commit_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dout_q   <= 1'b0;
            commit_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            dout_q   <= dout_d;
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout   = dout_q;
    assign commit = commit_q;
    assign sync   = sync2_q;

endmodule

// File: rtl/quad_filter.sv
// Quadrature input conditioning: per-channel glitch filters, warm-up FSM,
// Gray-code step/error decoding and a saturating illegal-transition counter.
module quad_filter
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_raw,
    input  logic        b_raw,
    input  logic        clear_err,
    output logic        a_out,
    output logic        b_out,
    output logic        step_valid,
    output logic        step_dir,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    logic dout_a, dout_b, commit_a, commit_b, sync_a, sync_b;

    quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (a_raw),
        .dout   (dout_a),
        .commit (commit_a),
        .sync   (sync_a)
    );

    quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (b_raw),
        .dout   (dout_b),
        .commit (commit_b),
        .sync   (sync_b)
    );

    quad_state_t state_q, state_d;
    logic [16:0] warm_q, warm_d;
    quad_ab_t    ab_q, ab_d;
    logic        valid_q, valid_d;
    logic        dir_q, dir_d;
    logic        errp_q, errp_d;
    logic [15:0] err_q, err_d;
    logic [2:0]  dec;

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        ab_d    = ab_q;
        valid_d = 1'b0;
        dir_d   = 1'b0;
        errp_d  = 1'b0;
        dec     = '0;
        case (state_q)
            INIT: begin
                // Outputs follow the synchronized pins so TRACK starts from the true level.
                ab_d = {sync_a, sync_b};
                if (warm_q == 17'(FILTER_CYCLES + 1)) begin
                    state_d = TRACK;
                end else begin
                    warm_d = warm_q + 17'd1;
                end
            end
            TRACK: begin
                if (commit_a || commit_b) begin
                    dec     = quad_decode(ab_q, {dout_a, dout_b});
                    ab_d    = {dout_a, dout_b};
                    valid_d = dec[2];
                    dir_d   = dec[1];
                    errp_d  = dec[0];
                end
            end
        endcase
    end

    // A clear coinciding with a visible error leaves that error counted.
    always_comb begin
        err_d = err_q;
        if (errp_q) begin
            if (clear_err) begin
                err_d = 16'd1;
            end else if (err_q != ERR_MAX) begin
                err_d = err_q + 16'd1;
            end
        end else if (clear_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            warm_q  <= '0;
            ab_q    <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            errp_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            ab_q    <= ab_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            errp_q  <= errp_d;
            err_q   <= err_d;
        end
    end

    assign a_out      = ab_q[1];
    assign b_out      = ab_q[0];
    assign step_valid = valid_q;
    assign step_dir   = dir_q;
    assign err_pulse  = errp_q;
    assign err_count  = err_q;

endmodule
